soda_controller: RTL and testbench
==================================

# soda_controller

Control FSM for the soda machine, directly upstream of `soda_datapath`. It watches the coin-detect line from the coin acceptor and the `tot_lt_s` compare result from the datapath, and drives the datapath's `tot_clr`/`tot_ld` strobes. It also owns the dispense pulse and an optional inactivity refund.

## Interface
Parameters:
- `DISP_CYCLES`, 4: length of the `d` (dispense) pulse in cycles; must be ≥1.
- `TIMEOUT_CYCLES`, 64: WAIT-state inactivity limit before refund; used only with `SODA_TIMEOUT_EN`; must be ≥2.

Ports:
- `clk`  in  1: single system clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `c`  in  1: coin-detect level from the coin acceptor; asynchronous; one coin per low→high transition.
- `tot_lt_s`  in  1: from datapath; 1 while running total < soda price.
- `tot_ld`  out  1: to datapath; load total + coin value at the next edge.
- `tot_clr`  out  1: to datapath; clear total at the next edge; active-high.
- `d`  out  1: dispense command.
- `refund`  out  1: one-cycle refund command; constant 0 without the macro.
- `busy`  out  1: high in DISP or REFUND.

## Operation
- `c` passes through a 2-FF synchroniser and a rising-edge detector, which sets a single `coin_pend` flag.
  - `coin_pend` clears in the cycle the FSM enters ADD.
  - A second edge while `coin_pend=1` is dropped; the coin acceptor must not deliver coins faster than one per 4 cycles.
- Moore FSM; all outputs are decoded from the state register, with no Mealy paths.
  - INIT: `tot_clr=1`; also clears the timeout counter and `have_coin`. Goes to WAIT.
  - WAIT: evaluates in priority order:
    1. `tot_lt_s=0` → DISP.
    2. Else `coin_pend=1` → ADD.
    3. Else, with the macro only, timeout expired → REFUND.
    4. Else stay in WAIT.
  - ADD: `tot_ld=1` for exactly one cycle; sets `have_coin`. Goes to WAIT.
  - DISP: `d=1` and `busy=1` for DISP_CYCLES cycles, counted by a down-counter loaded on entry. Goes to INIT.
  - REFUND: `refund=1` and `busy=1` for one cycle. Goes to INIT.
- Coins arriving in DISP, REFUND or INIT are held in `coin_pend` and processed in the first WAIT cycle after INIT. The coin therefore counts toward the next purchase.
- Price 0: `tot_lt_s=0` after INIT, so the machine cycles INIT→WAIT→DISP continuously. This is the defined behaviour.
- Encoding widths: state is 3 bits; the DISP counter is `$clog2(DISP_CYCLES+1)` bits; the timeout counter is `$clog2(TIMEOUT_CYCLES)` bits and saturates rather than wrapping.

## Timing
Reset values:
- While `rst=1`, state=INIT, so `tot_clr=1`.
- `tot_ld`, `d`, `refund`, `busy`, `coin_pend`, `have_coin`, the synchroniser and all counters are 0.
- Release of `rst` enters WAIT after the first edge.
- Reset mid-operation: asynchronous return to INIT. An in-progress dispense is truncated at once (`d` drops), and any pending coin is lost.

Coin latency:
- `c` rises before edge n; the synchroniser output is high after edge n+1.
- `coin_pend` is set at edge n+2; ADD is entered at edge n+3, with `tot_ld` high during cycle n+3.
- The datapath total updates at edge n+4; `tot_lt_s` is valid in the WAIT cycle after ADD.

Dispense latency:
- The first WAIT cycle with `tot_lt_s=0` is followed by `d` high at the next edge.
- `d` stays high exactly DISP_CYCLES cycles, then INIT (1 cycle), then WAIT.

Timeout:
- The counter increments each WAIT cycle while `have_coin=1`, and resets on ADD and on INIT.
- When the count reaches TIMEOUT_CYCLES−1 in WAIT with no coin pending and `tot_lt_s=1`, the next state is REFUND.
- If a coin is pending and the timeout expires in the same cycle, the coin wins.

## Configuration
- `SODA_TIMEOUT_EN` defined:
  - The timeout counter, `have_coin` and the REFUND state are compiled in.
  - An incomplete purchase is refunded, and the total cleared, after TIMEOUT_CYCLES idle WAIT cycles.
- `SODA_TIMEOUT_EN` undefined:
  - No counter and no REFUND state; `refund` is tied to 0.
  - WAIT holds indefinitely.

## Structure
- Shared header `soda_defs.vh`: state encodings `ST_INIT`, `ST_WAIT`, `ST_ADD`, `ST_DISP`, `ST_REFUND`, plus the default `DISP_CYCLES` and `TIMEOUT_CYCLES` constants. The datapath's bench uses the same header.
- Sub-module `soda_coin_sync` contains the 2-FF synchroniser, the edge detector and the `coin_pend` flag. It has inputs `clk`, `rst`, `c` and `take`, and output `coin_pend`.

## Test plan
Bench pairs `soda_controller` with a behavioural datapath: price 15, coin values per test.
- Reset: assert `rst` mid-DISP → `d` drops immediately, `tot_clr=1`. Release → WAIT after 1 edge; all other outputs 0.
- Coins 5, 5, 5 spaced 6 cycles apart → three single-cycle `tot_ld` pulses, each 3 cycles after its `c` rise. Then `d` high for exactly 4 cycles, then `tot_clr` for 1 cycle.
- Single coin 15 → one `tot_ld`, then `d` after 1 WAIT cycle. A coin inserted during DISP → `tot_ld` in the first WAIT cycle after INIT; the new total is 15 with no dispense until `tot_lt_s=0`.
- Macro on, `TIMEOUT_CYCLES=8`: one coin of 5, then idle → `refund` high 1 cycle after 8 WAIT cycles, followed by `tot_clr`. Macro off: same stimulus → `refund` stays 0 for 200 cycles.
- Macro on: coin edge timed to arrive in the timeout-expiry cycle → ADD taken and no refund.
- Price 0 → `d` pulses repeatedly with period DISP_CYCLES+2.

Source files
------------

// File: rtl/soda_controller_pkg.sv
// Shared definitions for the soda machine control path.
// State encodings ST_INIT..ST_REFUND, the enum built on them, and the default
// DISP_CYCLES / TIMEOUT_CYCLES values used as parameter defaults.
package soda_controller_pkg;

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_ADD    = 3'd2;
    localparam logic [2:0] ST_DISP   = 3'd3;
    localparam logic [2:0] ST_REFUND = 3'd4;

    localparam int unsigned SODA_DISP_CYCLES    = 4;
    localparam int unsigned SODA_TIMEOUT_CYCLES = 64;

    typedef enum logic [2:0] {
        StInit   = ST_INIT,
        StWait   = ST_WAIT,
        StAdd    = ST_ADD,
        StDisp   = ST_DISP,
        StRefund = ST_REFUND
    } soda_state_e;

endpackage

// File: rtl/soda_controller_coin_sync.sv
// soda_coin_sync: brings the asynchronous coin-detect level into the clock
// domain, detects its rising edge and holds one pending coin until taken.
// Ports:
//   clk        in  system clock, rising edge
//   rst        in  asynchronous active-high reset
//   c          in  raw coin-detect level (asynchronous)
//   take       in  controller is accepting the pending coin this cycle
//   coin_pend  out one coin is waiting to be added
module soda_coin_sync
    import soda_controller_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic c,
    input  logic take,
    output logic coin_pend
);

    logic sync1;
    logic sync2;
    logic sync_prev;
    logic rise;
    logic coin_pend_next;

    assign rise = sync2 & ~sync_prev;

    // Only one coin can be held; an edge arriving while one is pending is lost.
    always_comb begin
        coin_pend_next = coin_pend;
        if (take) begin
            coin_pend_next = 1'b0;
        end else if (rise) begin
            coin_pend_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
            coin_pend <= 1'b0;
        end else begin
            sync1     <= c;
            sync2     <= sync1;
            sync_prev <= sync2;
            coin_pend <= coin_pend_next;
        end
    end

endmodule

// File: rtl/soda_controller.sv
// soda_controller: Moore control FSM for the soda machine. Accepts coins,
// strobes the datapath to clear/accumulate the total, and issues a dispense
// pulse once the total reaches the price.
// Optional feature: define SODA_TIMEOUT_EN to compile in the inactivity
// refund (timeout counter, have_coin flag and REFUND state).
// Ports:
//   clk       in  system clock, rising edge
//   rst       in  asynchronous active-high reset
//   c         in  coin-detect level from the acceptor (asynchronous)
//   tot_lt_s  in  datapath: running total is below the price
//   tot_ld    out datapath: add coin value to total at next edge
//   tot_clr   out datapath: clear total at next edge
//   d         out dispense command, DISP_CYCLES cycles long
//   refund    out one-cycle refund command (0 without SODA_TIMEOUT_EN)
//   busy      out dispensing or refunding
module soda_controller
    import soda_controller_pkg::*;
#(
    parameter int unsigned DISP_CYCLES    = SODA_DISP_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = SODA_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic c,
    input  logic tot_lt_s,
    output logic tot_ld,
    output logic tot_clr,
    output logic d,
    output logic refund,
    output logic busy
);

    localparam int unsigned DW = $clog2(DISP_CYCLES + 1);

    if (DISP_CYCLES < 1) begin : g_bad_disp
        $error("DISP_CYCLES must be at least 1");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    soda_state_e   state;
    soda_state_e   state_next;
    logic [DW-1:0] disp_cnt;
    logic [DW-1:0] disp_cnt_next;
    logic          coin_pend;
    logic          take;
    logic          expired;

    soda_coin_sync u_coin_sync (
        .clk       (clk),
        .rst       (rst),
        .c         (c),
        .take      (take),
        .coin_pend (coin_pend)
    );

`ifdef SODA_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_cnt;
    logic [TW-1:0] to_cnt_next;
    logic          have_coin;
    logic          have_coin_next;

    assign expired = (state == StWait) && have_coin && (to_cnt == TO_LAST);

    // Counts idle WAIT cycles of a partial purchase; saturates at the limit.
    always_comb begin
        to_cnt_next    = to_cnt;
        have_coin_next = have_coin;
        unique case (state)
            StInit: begin
                to_cnt_next    = '0;
                have_coin_next = 1'b0;
            end
            StAdd: begin
                to_cnt_next    = '0;
                have_coin_next = 1'b1;
            end
            StWait: begin
                if (have_coin && (to_cnt != TO_LAST)) begin
                    to_cnt_next = to_cnt + TW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt    <= '0;
            have_coin <= 1'b0;
        end else begin
            to_cnt    <= to_cnt_next;
            have_coin <= have_coin_next;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_next    = state;
        disp_cnt_next = disp_cnt;
        take          = 1'b0;
        unique case (state)
            StInit: begin
                state_next = StWait;
            end
            StWait: begin
                // Dispense beats a pending coin, which beats the timeout.
                if (!tot_lt_s) begin
                    state_next    = StDisp;
                    disp_cnt_next = DW'(DISP_CYCLES);
                end else if (coin_pend) begin
                    state_next = StAdd;
                    take       = 1'b1;
                end else if (expired) begin
                    state_next = StRefund;
                end
            end
            StAdd: begin
                state_next = StWait;
            end
            StDisp: begin
                disp_cnt_next = disp_cnt - DW'(1);
                if (disp_cnt == DW'(1)) begin
                    state_next = StInit;
                end
            end
            StRefund: begin
                state_next = StInit;
            end
            default: begin
                state_next = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StInit;
            disp_cnt <= '0;
        end else begin
            state    <= state_next;
            disp_cnt <= disp_cnt_next;
        end
    end

    // Pure state decode so reset drops d immediately and raises tot_clr.
    always_comb begin
        tot_clr = (state == StInit);
        tot_ld  = (state == StAdd);
        d       = (state == StDisp);
`ifdef SODA_TIMEOUT_EN
        refund  = (state == StRefund);
`else
        refund  = 1'b0;
`endif
        busy    = d | refund;
    end

endmodule

// File: tb/tb_soda_controller.sv
module tb_soda_controller;

    localparam int DISP = 4;
    localparam int TOUT = 8;
    localparam int R    = 64;
`ifdef SODA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic c   = 1'b0;
    logic tot_lt_s, tot_ld, tot_clr, d, refund, busy;

    int price    = 15;
    int coin_val = 5;
    int dp_total;
    int n_total  = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Behavioural datapath
    always @(posedge clk) begin
        if (tot_clr) dp_total <= 0;
        else if (tot_ld) dp_total <= dp_total + coin_val;
    end
    assign tot_lt_s = (dp_total < price);

    soda_controller #(
        .DISP_CYCLES    (DISP),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .c        (c),
        .tot_lt_s (tot_lt_s),
        .tot_ld   (tot_ld),
        .tot_clr  (tot_clr),
        .d        (d),
        .refund   (refund),
        .busy     (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int qat(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    // ---------------- reference model ----------------
    // Timeline model: when the machine is idle it picks its next action from
    // the purchase rules and writes the resulting output pattern into future
    // cycle slots. Bit order {ld, clr, d, refund, busy}.
    logic [4:0] sched [R];
    bit  arrive [R];
    int  mk = 0;
    int  wait_at = 0;
    bit  pend, taken, have_coin, c_last;
    int  idle, m_total;

    task automatic model_step();
        logic [4:0] e;
        logic [4:0] got;
        bit arr;
        got = {tot_ld, tot_clr, d, refund, busy};
        if (rst) begin
            for (int i = 0; i < R; i++) begin
                sched[i]  = '0;
                arrive[i] = 1'b0;
            end
            pend = 0; taken = 0; have_coin = 0; idle = 0;
            wait_at = mk + 1;
            c_last = c;
            e = 5'b01000;
            m_total = 0;
        end else begin
            arr = arrive[mk % R];
            arrive[mk % R] = 1'b0;
            // a level rise is noticed by the controller three cycles later
            if (c && !c_last) arrive[(mk + 3) % R] = 1'b1;
            c_last = c;
            pend = taken ? 1'b0 : (pend | arr);
            taken = 1'b0;
            e = sched[mk % R];
            sched[mk % R] = '0;
            if (mk >= wait_at) begin
                if (m_total >= price) begin
                    for (int i = 1; i <= DISP; i++) sched[(mk + i) % R] = 5'b00101;
                    sched[(mk + DISP + 1) % R] = 5'b01000;
                    wait_at = mk + DISP + 2;
                    have_coin = 0; idle = 0;
                end else if (pend) begin
                    sched[(mk + 1) % R] = 5'b10000;
                    taken = 1'b1;
                    wait_at = mk + 2;
                    have_coin = 1; idle = 0;
                end else if (TO_EN && have_coin) begin
                    if (idle == TOUT - 1) begin
                        sched[(mk + 1) % R] = 5'b00011;
                        sched[(mk + 2) % R] = 5'b01000;
                        wait_at = mk + 3;
                        have_coin = 0; idle = 0;
                    end else begin
                        idle++;
                    end
                end
            end
            if (e[3]) m_total = 0;
            else if (e[4]) m_total += coin_val;
        end
        check("model {ld,clr,d,refund,busy}", int'(got), int'(e));
        mk++;
    endtask

    always @(negedge clk) model_step();

    // ---------------- stimulus helpers ----------------
    int cyc = 0;
    int ld_q[$], d_q[$], clr_q[$], ref_q[$];

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        if (tot_ld)  ld_q.push_back(cyc);
        if (d)       d_q.push_back(cyc);
        if (tot_clr) clr_q.push_back(cyc);
        if (refund)  ref_q.push_back(cyc);
    endtask

    task automatic clear_q();
        ld_q.delete(); d_q.delete(); clr_q.delete(); ref_q.delete();
    endtask

    task automatic do_reset(input int p, input int v);
        c = 1'b0;
        rst = 1'b1;
        price = p;
        coin_val = v;
        step();
        step();
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        clear_q();
    endtask

    task automatic coin(output int r);
        r = cyc;
        c = 1'b1;
        step();
        step();
        c = 1'b0;
    endtask

    task automatic run_until(input int t);
        for (int i = 0; i < 400 && cyc < t; i++) step();
    endtask

    typedef struct {
        int price;
        int val;
        int ncoins;
        int exp_ld;
        int exp_d;
        int exp_ref;
    } row_t;

    row_t rows[6];

    initial begin
        int r, r2, a, next_rise, c_off_at;
        int rises[3];
        int drise[$];

        rows[0] = '{15, 5, 3, 3, DISP, 0};
        rows[1] = '{15, 15, 1, 1, DISP, 0};
        rows[2] = '{15, 10, 2, 2, DISP, 0};
        rows[3] = '{15, 5, 2, 2, 0, TO_EN ? 1 : 0};
        rows[4] = '{15, 25, 1, 1, DISP, 0};
        rows[5] = '{15, 5, 4, 4, DISP, TO_EN ? 1 : 0};

        // Reset state
        @(posedge clk);
        #2;
        check("reset tot_clr", int'(tot_clr), 1);
        check("reset others {ld,d,refund,busy}", int'({tot_ld, d, refund, busy}), 0);
        do_reset(15, 5);
        check("wait after release", int'({tot_ld, tot_clr, d, refund, busy}), 0);

        // Table-driven purchases
        foreach (rows[k]) begin
            do_reset(rows[k].price, rows[k].val);
            for (int i = 0; i < rows[k].ncoins; i++) begin
                coin(r);
                for (int j = 0; j < 4; j++) step();
            end
            for (int j = 0; j < 30; j++) step();
            check($sformatf("row%0d ld pulses", k), ld_q.size(), rows[k].exp_ld);
            check($sformatf("row%0d d cycles", k), d_q.size(), rows[k].exp_d);
            check($sformatf("row%0d refunds", k), ref_q.size(), rows[k].exp_ref);
        end

        // Three 5-coins, 6 cycles apart: latency and dispense shape
        do_reset(15, 5);
        for (int j = 0; j < 3; j++) begin
            coin(rises[j]);
            for (int i = 0; i < 4; i++) step();
        end
        for (int i = 0; i < 10; i++) step();
        for (int j = 0; j < 3; j++)
            check($sformatf("coin%0d ld latency", j), qat(ld_q, j) - rises[j], 4);
        check("ld pulse count", ld_q.size(), 3);
        check("d start after last ld", qat(d_q, 0) - qat(ld_q, 2), 2);
        check("d length", d_q.size(), DISP);
        check("d contiguous", qat(d_q, DISP - 1) - qat(d_q, 0), DISP - 1);
        check("clr after d", qat(clr_q, 0), qat(d_q, DISP - 1) + 1);
        check("clr length", clr_q.size(), 1);

        // Single 15-coin, then a coin inserted during DISP
        do_reset(15, 15);
        coin(r);
        run_until(r + 7);
        c = 1'b1;
        step();
        step();
        c = 1'b0;
        for (int i = 0; i < 30 && cyc < r + 20; i++) begin
            step();
            if (cyc == r + 13) check("total after held coin", dp_total, 15);
        end
        check("15-coin d after 1 wait", qat(d_q, 0) - qat(ld_q, 0), 2);
        check("held coin ld after INIT", qat(ld_q, 1) - qat(ld_q, 0), 8);
        check("redispense after held coin", qat(d_q, DISP) - qat(ld_q, 1), 2);

        // Reset mid-DISP drops d at once and loses a pending coin
        do_reset(15, 15);
        coin(r);
        run_until(r + 7);
        c = 1'b1;
        step();
        c = 1'b0;
        check("in DISP before reset", int'(d), 1);
        rst = 1'b1;
        #1;
        check("async reset d", int'(d), 0);
        check("async reset tot_clr", int'(tot_clr), 1);
        check("async reset busy", int'(busy), 0);
        step();
        @(negedge clk);
        #1 rst = 1'b0;
        step();
        clear_q();
        check("after mid-DISP reset", int'({tot_ld, tot_clr, d, refund, busy}), 0);
        for (int i = 0; i < 15; i++) step();
        check("pending coin lost", ld_q.size(), 0);

        // Price 0: continuous dispense
        do_reset(0, 5);
        for (int i = 0; i < 30; i++) step();
        foreach (d_q[i]) if (i == 0 || d_q[i] != d_q[i - 1] + 1) drise.push_back(d_q[i]);
        check("price0 period 1", qat(drise, 1) - qat(drise, 0), DISP + 2);
        check("price0 period 2", qat(drise, 2) - qat(drise, 1), DISP + 2);

        // Inactivity with one coin
        do_reset(15, 5);
        coin(r);
        a = r + 4;
        run_until(r + 24);
        check("timeout coin ld", qat(ld_q, 0), a);
`ifdef SODA_TIMEOUT_EN
        check("refund count", ref_q.size(), 1);
        check("refund cycle", qat(ref_q, 0), a + 9);
        check("clr after refund", qat(clr_q, 0), a + 10);
`else
        for (int i = 0; i < 200; i++) step();
        check("no refund without timeout", ref_q.size(), 0);
        check("no dispense while idle", d_q.size(), 0);
`endif

        // Coin arrives in the timeout-expiry cycle: coin wins
        do_reset(15, 5);
        coin(r);
        a = r + 4;
        run_until(r + 9);
        coin(r2);
        run_until(r + 24);
        check("expiry coin ld", qat(ld_q, 1), a + 9);
        check("expiry refund", qat(ref_q, 0), TO_EN ? a + 18 : -1);

        // Random coin traffic against the model
        do_reset(15, 5);
        next_rise = cyc + 3;
        c_off_at = -1;
        for (int i = 0; i < 1500; i++) begin
            if (cyc == c_off_at) c = 1'b0;
            if (cyc >= next_rise) begin
                c = 1'b1;
                c_off_at = cyc + int'($urandom_range(1, 3));
                next_rise = cyc + int'($urandom_range(4, 14));
            end
            step();
        end
        c = 1'b0;
        for (int i = 0; i < 5; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
